// File: rtl/hack_memory_if.sv
// Hack data-port bundle: CPU load/store port, keyboard strobe and the display pixel stream.
interface hack_memory_if;
  logic [14:0] MAddr;
  logic [15:0] MWrite;
  logic        loadM;
  logic [15:0] MRead;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic [12:0] pix_addr;
  logic        frame_start;

  modport master (
    output MAddr, MWrite, loadM, kbd_valid, kbd_code, pix_ready,
    input  MRead, pix_valid, pix_data, pix_addr, frame_start
  );

  modport slave (
    input  MAddr, MWrite, loadM, kbd_valid, kbd_code, pix_ready,
    output MRead, pix_valid, pix_data, pix_addr, frame_start
  );
endinterface

// File: rtl/hack_memory.sv
// Hack data memory: RAM + screen + keyboard register with combinational reads and clocked writes,
// plus a scanner that streams the screen buffer continuously over valid/ready, one word per cycle.
module hack_memory #(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_BASE  = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_ADDR     = 24576
) (
  input logic            clk,
  input logic            rst,
  hack_memory_if.slave   bus
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);

  localparam logic [14:0] RAM_END = 15'(RAM_WORDS);
  localparam logic [14:0] SCR_LO  = 15'(SCREEN_BASE);
  localparam logic [14:0] SCR_END = 15'(SCREEN_BASE + SCREEN_WORDS);
  localparam logic [14:0] KBD     = 15'(KBD_ADDR);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [15:0] ram    [RAM_WORDS];
  logic [15:0] screen [SCREEN_WORDS];
  logic [15:0] kbd_reg;

  logic        is_ram, is_scr, is_kbd;
  logic [15:0] rd_data;

  logic [0:0]        state;
  logic [SCR_AW-1:0] scan_ptr;
  logic [SCR_AW-1:0] next_ptr;
  logic [15:0]       pix_word;
  logic              pix_on;

  assign is_ram = (bus.MAddr < RAM_END);
  assign is_scr = (bus.MAddr >= SCR_LO) && (bus.MAddr < SCR_END);
  assign is_kbd = (bus.MAddr == KBD);

  // Screen base is a multiple of the screen size, so the low address bits index it directly.
  always_comb begin
    rd_data = 16'h0000;
    if (is_ram)
      rd_data = ram[bus.MAddr[RAM_AW-1:0]];
    else if (is_scr)
      rd_data = screen[bus.MAddr[SCR_AW-1:0]];
    else if (is_kbd)
      rd_data = kbd_reg;
  end

  assign bus.MRead = rd_data;

  // Storage is deliberately not cleared by reset; only the write is gated.
  always_ff @(posedge clk) begin
    if (rst && bus.loadM) begin
      if (is_ram)
        ram[bus.MAddr[RAM_AW-1:0]] <= bus.MWrite;
      else if (is_scr)
        screen[bus.MAddr[SCR_AW-1:0]] <= bus.MWrite;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      kbd_reg <= 16'h0000;
    else if (bus.kbd_valid)
      kbd_reg <= bus.kbd_code;
  end

  assign next_ptr = scan_ptr + SCR_AW'(1);

  // Scanner reads screen with the pre-edge contents, so a same-edge CPU write to the
  // word being loaded is seen only on the next frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      scan_ptr <= '0;
      pix_word <= 16'h0000;
      pix_on   <= 1'b0;
    end else if (state == IDLE) begin
      state    <= STREAM;
      scan_ptr <= '0;
      pix_word <= screen[0];
      pix_on   <= 1'b1;
    end else if (pix_on && bus.pix_ready) begin
      scan_ptr <= next_ptr;
      pix_word <= screen[next_ptr];
    end
  end

  assign bus.pix_valid   = pix_on;
  assign bus.pix_data    = pix_word;
  assign bus.pix_addr    = scan_ptr;
  assign bus.frame_start = pix_on && (scan_ptr == '0);

endmodule
